// File: rtl/double_trouble_sweeper.sv
// Self-test sweeper for a 4-input "at least two high" gate: walks all 16 codes and checks out.
// Latency: each code held HOLD_CYCLES cycles, sampled on the last; done follows 16*HOLD_CYCLES cycles after start.
// Backpressure: none; start is accepted only in IDLE/DONE and ignored while a sweep runs.
module double_trouble_sweeper #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       out,
  output logic       in0,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_code
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] code_q, code_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] drv_q, drv_d;
  logic [4:0] err_q, err_d;
  logic       fail_vld_q, fail_vld_d;
  logic [3:0] fail_code_q, fail_code_d;

  logic [2:0] pop;
  logic       expected;

  // Reference value for the current code: true when two or more bits are set.
  always_comb begin
    pop      = {2'b00, code_q[0]} + {2'b00, code_q[1]} + {2'b00, code_q[2]} + {2'b00, code_q[3]};
    expected = (pop >= 3'd2);
  end

  // Next-state logic: sweep sequencing, sampling at the end of each hold window, result capture.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    hold_d      = hold_q;
    drv_d       = drv_q;
    err_d       = err_q;
    fail_vld_d  = fail_vld_q;
    fail_code_d = fail_code_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          code_d      = 4'd0;
          hold_d      = 8'd0;
          drv_d       = 4'd0;
          err_d       = 5'd0;
          fail_vld_d  = 1'b0;
          fail_code_d = 4'd0;
        end
      end
      RUN: begin
        if (hold_q == HOLD_LAST) begin
          if (out != expected) begin
            err_d = err_q + 5'd1;
            // Only the first failing code is kept; later ones just count.
            if (!fail_vld_q) begin
              fail_vld_d  = 1'b1;
              fail_code_d = code_q;
            end
          end
          if (code_q == 4'd15) begin
            // Finish instead of wrapping; the gate inputs are parked at zero.
            state_d = DONE;
            code_d  = 4'd0;
            hold_d  = 8'd0;
            drv_d   = 4'd0;
          end else begin
            code_d = code_q + 4'd1;
            hold_d = 8'd0;
            drv_d  = code_q + 4'd1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; rst overrides everything, including a running sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      code_q      <= 4'd0;
      hold_q      <= 8'd0;
      drv_q       <= 4'd0;
      err_q       <= 5'd0;
      fail_vld_q  <= 1'b0;
      fail_code_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      hold_q      <= hold_d;
      drv_q       <= drv_d;
      err_q       <= err_d;
      fail_vld_q  <= fail_vld_d;
      fail_code_q <= fail_code_d;
    end
  end

  // Gate inputs come straight from a register so they change cleanly once per code.
  assign {in3, in2, in1, in0} = drv_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign pass       = (state_q == DONE) && (err_q == 5'd0);
  assign err_count  = err_q;
  assign fail_valid = fail_vld_q;
  assign fail_code  = fail_code_q;

endmodule

// File: tb/tb_double_trouble_sweeper.sv
// Bench for double_trouble_sweeper: two instances (hold 2 and hold 1) driving a behavioural gate.
// Latency: expected codes and results are queued at start and popped as the sweep progresses.
// Backpressure: none; the bench drives start/rst directly.
module tb_double_trouble_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_a, start_b, out_a, out_b;
  logic       in0_a, in1_a, in2_a, in3_a, in0_b, in1_b, in2_b, in3_b;
  logic       busy_a, done_a, pass_a, fv_a, busy_b, done_b, pass_b, fv_b;
  logic [4:0] err_a, err_b;
  logic [3:0] fc_a, fc_b, in_a, in_b;
  int         mode_a, mode_b;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0] err;
    logic       fv;
    logic [3:0] fc;
    logic       pass;
  } res_t;

  res_t       res_sb[$];
  logic [3:0] code_sb[$];

  assign in_a = {in3_a, in2_a, in1_a, in0_a};
  assign in_b = {in3_b, in2_b, in1_b, in0_b};

  // Gate models: 0 correct (sum of products), 1 stuck low, 2 stuck high, 3 in0&in1.
  function automatic logic gate(input int mode, input logic [3:0] c);
    case (mode)
      0:       return (c[0] & c[1]) | (c[0] & c[2]) | (c[0] & c[3]) |
                      (c[1] & c[2]) | (c[1] & c[3]) | (c[2] & c[3]);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return c[0] & c[1];
    endcase
  endfunction

  always_comb out_a = gate(mode_a, in_a);
  always_comb out_b = gate(mode_b, in_b);

  double_trouble_sweeper #(.HOLD_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .out(out_a),
    .in0(in0_a), .in1(in1_a), .in2(in2_a), .in3(in3_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_valid(fv_a), .fail_code(fc_a)
  );

  double_trouble_sweeper #(.HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .out(out_b),
    .in0(in0_b), .in1(in1_b), .in2(in2_b), .in3(in3_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_valid(fv_b), .fail_code(fc_b)
  );

  function automatic logic [3:0] cur_in(input bit sel);
    return sel ? in_b : in_a;
  endfunction

  function automatic logic cur_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic logic cur_done(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  function automatic res_t cur_res(input bit sel);
    res_t r;
    if (sel) r = '{err: err_b, fv: fv_b, fc: fc_b, pass: pass_b};
    else     r = '{err: err_a, fv: fv_a, fc: fc_a, pass: pass_a};
    return r;
  endfunction

  // Queue expected codes and the final result for one sweep under a given gate model.
  task automatic push_expect(input int mode, input int hold);
    res_t       e;
    logic [3:0] lc;
    e = '0;
    for (int c = 0; c < 16; c++) begin
      lc = 4'(c);
      if (gate(mode, lc) !== ($countones(lc) >= 2)) begin
        e.err = e.err + 5'd1;
        if (!e.fv) begin
          e.fv = 1'b1;
          e.fc = lc;
        end
      end
      for (int h = 0; h < hold; h++) code_sb.push_back(lc);
    end
    e.pass = (e.err == 5'd0);
    res_sb.push_back(e);
  endtask

  // Check the code presented each cycle of `cycles` cycles against the scoreboard.
  task automatic check_codes(input bit sel, input int cycles, input string name);
    logic [3:0] ec;
    for (int i = 0; i < cycles; i++) begin
      ec = code_sb.pop_front();
      total++;
      if (cur_busy(sel) !== 1'b1 || cur_in(sel) !== ec) begin
        bad++;
        $display("FAIL %s cycle %0d: busy=%b in=%0d, want busy=1 in=%0d",
                 name, i, cur_busy(sel), cur_in(sel), ec);
      end
      @(posedge clk); #1;
    end
  endtask

  // One full sweep: start pulse, per-cycle code monitor, end-of-sweep result check.
  task automatic sweep(input bit sel, input int mode, input int hold, input string name);
    res_t r;
    if (sel) mode_b = mode; else mode_a = mode;
    push_expect(mode, hold);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    check_codes(sel, 16 * hold, name);
    total++;
    if (cur_done(sel) !== 1'b1 || cur_busy(sel) !== 1'b0 || cur_in(sel) !== 4'd0) begin
      bad++;
      $display("FAIL %s end: done=%b busy=%b in=%0d, want done=1 busy=0 in=0",
               name, cur_done(sel), cur_busy(sel), cur_in(sel));
    end
    r = res_sb.pop_front();
    total++;
    if (cur_res(sel) !== r) begin
      bad++;
      $display("FAIL %s result: err=%0d fv=%b fc=%0d pass=%b, want err=%0d fv=%b fc=%0d pass=%b",
               name, cur_res(sel).err, cur_res(sel).fv, cur_res(sel).fc, cur_res(sel).pass,
               r.err, r.fv, r.fc, r.pass);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if ({in_a, busy_a, done_a, pass_a, err_a, fv_a, fc_a} !== 17'd0) begin
      bad++;
      $display("FAIL reset_a: in=%0d busy=%b done=%b pass=%b err=%0d fv=%b fc=%0d, want all 0",
               in_a, busy_a, done_a, pass_a, err_a, fv_a, fc_a);
    end
    total++;
    if ({in_b, busy_b, done_b, pass_b, err_b, fv_b, fc_b} !== 17'd0) begin
      bad++;
      $display("FAIL reset_b: in=%0d busy=%b done=%b pass=%b err=%0d fv=%b fc=%0d, want all 0",
               in_b, busy_b, done_b, pass_b, err_b, fv_b, fc_b);
    end
  endtask

  task automatic test_clean();
    sweep(1'b0, 0, 2, "clean_h2");
  endtask

  task automatic test_faulty_gates();
    sweep(1'b0, 1, 2, "stuck0_h2");
    sweep(1'b0, 2, 2, "stuck1_h2");
    sweep(1'b0, 0, 2, "restart_clean_h2");
  endtask

  // start held high through RUN must not restart; rst at code 7 aborts to IDLE.
  task automatic test_abort();
    mode_a = 0;
    for (int c = 0; c < 7; c++) begin
      code_sb.push_back(4'(c));
      code_sb.push_back(4'(c));
    end
    start_a = 1'b1;
    @(posedge clk); #1;
    check_codes(1'b0, 14, "abort_start_high");
    total++;
    if (in_a !== 4'd7 || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: in=%0d busy=%b, want in=7 busy=1", in_a, busy_a);
    end
    start_a = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({in_a, busy_a, done_a, pass_a, err_a, fv_a, fc_a} !== 17'd0) begin
      bad++;
      $display("FAIL abort_idle: in=%0d busy=%b done=%b err=%0d fv=%b fc=%0d, want all 0",
               in_a, busy_a, done_a, err_a, fv_a, fc_a);
    end
    @(posedge clk); #1;
    total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || in_a !== 4'd0) begin
      bad++;
      $display("FAIL abort_stay_idle: busy=%b done=%b in=%0d, want 0 0 0", busy_a, done_a, in_a);
    end
    sweep(1'b0, 0, 2, "after_abort_h2");
  endtask

  task automatic test_hold1();
    sweep(1'b1, 3, 1, "and01_h1");
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    mode_a  = 0;
    mode_b  = 0;
    test_reset();
    test_clean();
    test_faulty_gates();
    test_abort();
    test_hold1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
